// File: rtl/sudoku_grid_checker.sv
// Sequential Sudoku grid checker: captures a one-hot 81-cell grid and checks one
// group per cycle (9 rows, 9 columns, 9 boxes), reporting pass/fail and the first failing group.

module sudoku_cell_chk #(
  parameter int VEC_W = 9
) (
  input  logic [VEC_W-1:0] cell_i,
  output logic             one_hot_o
);
  assign one_hot_o = (cell_i != '0) && ((cell_i & (cell_i - VEC_W'(1))) == '0);
endmodule

module sudoku_grid_checker #(
  parameter bit         EARLY_EXIT = 1'b0,
  parameter logic [4:0] ERR_NONE   = 5'd31
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [728:0] bin_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         valid_o,
  output logic [4:0]   err_group_o
);
  localparam int NUM_LANES  = 9;
  localparam int VEC_W      = 9;
  localparam int NUM_CELLS  = 81;
  localparam logic [4:0] LAST_GROUP = 5'd26;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                          state_q, state_d;
  logic [NUM_CELLS-1:0][VEC_W-1:0]     grid_q, grid_d;
  logic [4:0]                          g_q, g_d;
  logic [4:0]                          first_q, first_d;
  logic                                fail_q, fail_d;
  logic                                valid_q, valid_d;
  logic [4:0]                          err_q, err_d;

  logic [NUM_LANES-1:0][VEC_W-1:0]     lane_cell;
  logic [NUM_LANES-1:0]                lane_ok;
  logic [VEC_W-1:0]                    grp_or;
  logic                                grp_pass;
  logic                                last_step;

  // Cell index of lane j within group g; out-of-range groups fold to cell 0.
  function automatic logic [6:0] cell_idx(input logic [4:0] g, input int j);
    int r, c, b;
    r = 0;
    c = 0;
    b = 0;
    if (g < 5'd9) begin
      r = int'(g);
      c = j;
    end else if (g < 5'd18) begin
      r = j;
      c = int'(g) - 9;
    end else begin
      b = int'(g) - 18;
      r = 3 * (b / 3) + j / 3;
      c = 3 * (b % 3) + j % 3;
    end
    if (r > 8 || c > 8) return 7'd0;
    return 7'(r * 9 + c);
  endfunction

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assign lane_cell[j] = grid_q[cell_idx(g_q, j)];
    sudoku_cell_chk #(.VEC_W(VEC_W)) u_chk (
      .cell_i    (lane_cell[j]),
      .one_hot_o (lane_ok[j])
    );
  end

  always_comb begin
    grp_or = '0;
    for (int j = 0; j < NUM_LANES; j++) grp_or = grp_or | lane_cell[j];
    grp_pass = (&lane_ok) && (grp_or == {VEC_W{1'b1}});
  end

  assign last_step = (g_q == LAST_GROUP) || (EARLY_EXIT && !grp_pass);

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    g_d     = g_q;
    first_d = first_q;
    fail_d  = fail_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          grid_d  = bin_i;
          g_d     = 5'd0;
          first_d = ERR_NONE;
          fail_d  = 1'b0;
          valid_d = 1'b0;
          err_d   = ERR_NONE;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!grp_pass) begin
          fail_d = 1'b1;
          if (!fail_q) first_d = g_q;
        end
        // Results become visible together with the done pulse.
        if (last_step) begin
          valid_d = !fail_d;
          err_d   = first_d;
          state_d = S_DONE;
        end else begin
          g_d = g_q + 5'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      g_q     <= 5'd0;
      first_q <= ERR_NONE;
      fail_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      g_q     <= g_d;
      first_q <= first_d;
      fail_q  <= fail_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q == S_CHECK);
  assign done_o      = (state_q == S_DONE);
  assign valid_o     = valid_q;
  assign err_group_o = err_q;

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed bench for sudoku_grid_checker: one full-scan instance and one early-exit
// instance share clock, reset and grid input.

module tb_sudoku_grid_checker;
  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1;
  logic [728:0] bin;
  logic         busy0, done0, valid0, busy1, done1, valid1;
  logic [4:0]   err0, err1;

  int total = 0;
  int bad   = 0;

  // per-run observations (cycle k = k-th cycle after the start edge)
  int   bcnt0, fb0, lb0, dn0, dc0, ov0;
  int   bcnt1, fb1, lb1, dn1, dc1, ov1;
  logic v0, v1;
  logic [4:0] e0, e1;

  always #5 clk = ~clk;

  sudoku_grid_checker #(.EARLY_EXIT(1'b0), .ERR_NONE(5'd31)) u_full (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .bin_i(bin),
    .busy_o(busy0), .done_o(done0), .valid_o(valid0), .err_group_o(err0)
  );

  sudoku_grid_checker #(.EARLY_EXIT(1'b1), .ERR_NONE(5'd31)) u_early (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .bin_i(bin),
    .busy_o(busy1), .done_o(done1), .valid_o(valid1), .err_group_o(err1)
  );

  // kind 0 solved, 1 cell(4,4) blank, 2 row0 cols 0/1 swapped, 3 shifted rows, 4 cell(0,0) multi-bit
  function automatic logic [728:0] mk(input int kind);
    logic [80:0][8:0] g;
    logic [8:0] t;
    int d;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++) begin
        if (kind == 3) d = ((r + c) % 9) + 1;
        else           d = ((r * 3 + r / 3 + c) % 9) + 1;
        g[r * 9 + c] = 9'd1 << (d - 1);
      end
    if (kind == 1) g[40] = 9'd0;
    if (kind == 2) begin t = g[0]; g[0] = g[1]; g[1] = t; end
    if (kind == 4) g[0] = 9'b000000011;
    return g;
  endfunction

  // Called just after a rising edge; start sampled at the next edge (E0).
  task automatic run(input logic [728:0] g, input int zap_cyc, input bit poke, input int ncyc);
    bin = g; start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    bcnt0 = 0; fb0 = 0; lb0 = 0; dn0 = 0; dc0 = 0; ov0 = 0; v0 = 1'bx; e0 = 'x;
    bcnt1 = 0; fb1 = 0; lb1 = 0; dn1 = 0; dc1 = 0; ov1 = 0; v1 = 1'bx; e1 = 'x;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (busy0) begin bcnt0++; if (fb0 == 0) fb0 = k; lb0 = k; end
      if (busy1) begin bcnt1++; if (fb1 == 0) fb1 = k; lb1 = k; end
      if (done0) begin dn0++; dc0 = k; v0 = valid0; e0 = err0; if (busy0) ov0++; end
      if (done1) begin dn1++; dc1 = k; v1 = valid1; e1 = err1; if (busy1) ov1++; end
      @(posedge clk); #1;
      if (k == zap_cyc) begin bin = '0; start0 = poke; start1 = poke; end
      if (k == zap_cyc + 1) begin start0 = 1'b0; start1 = 1'b0; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; bin = mk(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done0); end
    total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid0); end
    total++; if (err0 !== 5'd31) begin bad++; $display("FAIL reset_err got=%0d exp=31", err0); end
    total++; if (err1 !== 5'd31 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_early got err=%0d busy=%b exp err=31 busy=0", err1, busy1); end
    @(posedge clk); #1;
  endtask

  task automatic test_solved;
    run(mk(0), 0, 1'b0, 32);
    total++; if (fb0 !== 1 || lb0 !== 27 || bcnt0 !== 27) begin bad++; $display("FAIL solved_busy got first=%0d last=%0d cnt=%0d exp 1/27/27", fb0, lb0, bcnt0); end
    total++; if (dc0 !== 28 || dn0 !== 1) begin bad++; $display("FAIL solved_done got cyc=%0d n=%0d exp cyc=28 n=1", dc0, dn0); end
    total++; if (ov0 !== 0) begin bad++; $display("FAIL solved_overlap got=%0d exp=0", ov0); end
    total++; if (v0 !== 1'b1 || e0 !== 5'd31) begin bad++; $display("FAIL solved_result got v=%b err=%0d exp v=1 err=31", v0, e0); end
    total++; if (dc1 !== 28 || v1 !== 1'b1 || e1 !== 5'd31) begin bad++; $display("FAIL solved_early got cyc=%0d v=%b err=%0d exp 28/1/31", dc1, v1, e1); end
    total++; if (valid0 !== 1'b1 || err0 !== 5'd31) begin bad++; $display("FAIL solved_hold got v=%b err=%0d exp v=1 err=31", valid0, err0); end
  endtask

  task automatic test_blank_cell;
    run(mk(1), 0, 1'b0, 32);
    total++; if (dc0 !== 28 || v0 !== 1'b0 || e0 !== 5'd4) begin bad++; $display("FAIL blank_full got cyc=%0d v=%b err=%0d exp 28/0/4", dc0, v0, e0); end
    total++; if (dc1 !== 6 || v1 !== 1'b0 || e1 !== 5'd4) begin bad++; $display("FAIL blank_early got cyc=%0d v=%b err=%0d exp 6/0/4", dc1, v1, e1); end
    total++; if (bcnt1 !== 5 || ov1 !== 0) begin bad++; $display("FAIL blank_early_busy got cnt=%0d ov=%0d exp 5/0", bcnt1, ov1); end
  endtask

  task automatic test_col_fail;
    run(mk(2), 0, 1'b0, 32);
    total++; if (v0 !== 1'b0 || e0 !== 5'd9) begin bad++; $display("FAIL col_full got v=%b err=%0d exp v=0 err=9", v0, e0); end
    total++; if (dc1 !== 11 || e1 !== 5'd9) begin bad++; $display("FAIL col_early got cyc=%0d err=%0d exp 11/9", dc1, e1); end
  endtask

  task automatic test_box_fail;
    run(mk(3), 0, 1'b0, 32);
    total++; if (v0 !== 1'b0 || e0 !== 5'd18 || dc0 !== 28) begin bad++; $display("FAIL box_full got v=%b err=%0d cyc=%0d exp 0/18/28", v0, e0, dc0); end
    total++; if (dc1 !== 20 || e1 !== 5'd18) begin bad++; $display("FAIL box_early got cyc=%0d err=%0d exp 20/18", dc1, e1); end
  endtask

  task automatic test_multibit;
    run(mk(4), 0, 1'b0, 32);
    total++; if (v0 !== 1'b0 || e0 !== 5'd0) begin bad++; $display("FAIL multibit_full got v=%b err=%0d exp v=0 err=0", v0, e0); end
    total++; if (dc1 !== 2 || e1 !== 5'd0) begin bad++; $display("FAIL multibit_early got cyc=%0d err=%0d exp 2/0", dc1, e1); end
  endtask

  task automatic test_bin_change;
    run(mk(0), 3, 1'b0, 32);
    total++; if (v0 !== 1'b1 || e0 !== 5'd31 || dc0 !== 28) begin bad++; $display("FAIL binchg_full got v=%b err=%0d cyc=%0d exp 1/31/28", v0, e0, dc0); end
    total++; if (v1 !== 1'b1 || dc1 !== 28) begin bad++; $display("FAIL binchg_early got v=%b cyc=%0d exp 1/28", v1, dc1); end
  endtask

  task automatic test_start_busy;
    // extra start in cycle 5 (busy) with an all-zero grid
    run(mk(0), 4, 1'b1, 34);
    total++; if (bcnt0 !== 27 || dn0 !== 1 || v0 !== 1'b1) begin bad++; $display("FAIL start_busy got cnt=%0d n=%0d v=%b exp 27/1/1", bcnt0, dn0, v0); end
    // extra start in cycle 28 (done cycle)
    run(mk(0), 27, 1'b1, 34);
    total++; if (bcnt0 !== 27 || dn0 !== 1 || lb0 !== 27) begin bad++; $display("FAIL start_done got cnt=%0d n=%0d last=%0d exp 27/1/27", bcnt0, dn0, lb0); end
    total++; if (busy0 !== 1'b0 || valid0 !== 1'b1) begin bad++; $display("FAIL start_done_idle got busy=%b v=%b exp 0/1", busy0, valid0); end
  endtask

  task automatic test_reset_mid;
    int dcount;
    bin = mk(1); start0 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start0 = 1'b0;
    @(negedge clk);
    total++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL rstmid_busy got %b/%b exp 0/0", busy0, busy1); end
    total++; if (valid0 !== 1'b0 || err0 !== 5'd31 || err1 !== 5'd31) begin bad++; $display("FAIL rstmid_outs got v=%b err=%0d/%0d exp 0/31/31", valid0, err0, err1); end
    dcount = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (done0 || done1 || busy0) dcount++;
    end
    total++; if (dcount !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d exp=0", dcount); end
    @(posedge clk); #1;
    run(mk(0), 0, 1'b0, 32);
    total++; if (dc0 !== 28 || v0 !== 1'b1 || e0 !== 5'd31) begin bad++; $display("FAIL rstmid_fresh got cyc=%0d v=%b err=%0d exp 28/1/31", dc0, v0, e0); end
  endtask

  task automatic test_back_to_back;
    run(mk(0), 0, 1'b0, 28);
    total++; if (dc0 !== 28 || v0 !== 1'b1) begin bad++; $display("FAIL b2b_first got cyc=%0d v=%b exp 28/1", dc0, v0); end
    run(mk(2), 0, 1'b0, 32);
    total++; if (dc0 !== 28 || bcnt0 !== 27 || v0 !== 1'b0 || e0 !== 5'd9) begin bad++; $display("FAIL b2b_second got cyc=%0d cnt=%0d v=%b err=%0d exp 28/27/0/9", dc0, bcnt0, v0, e0); end
    total++; if (dc1 !== 11 || e1 !== 5'd9) begin bad++; $display("FAIL b2b_early got cyc=%0d err=%0d exp 11/9", dc1, e1); end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; bin = '0;
    test_reset();
    test_solved();
    test_blank_cell();
    test_col_fail();
    test_box_fail();
    test_multibit();
    test_bin_change();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sudoku_grid_checker.md
Name: sudoku_grid_checker

Overview:
- Sequential checker directly downstream of the hex-to-one-hot grid converter.
- Consumes the 729-bit one-hot grid (81 cells x 9 bits) and checks one group per cycle: 9 rows, then 9 columns, then 9 3x3 boxes.
- Reports pass/fail and the index of the first failing group through a start/done handshake.
- Sits between the converter and the top-level sudoku_check result logic.

Parameters:
- EARLY_EXIT, 0, 1 = terminate at first failing group; 0 = always scan all 27 groups (fixed latency).
- ERR_NONE, 31, value driven on err_group when no group fails (5-bit).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request check; accepted only in IDLE
- bin  input  729  one-hot grid; cell i = row*9+col occupies bin[i*9+8:i*9]; digit d = bit d-1; 0 = blank/invalid
- busy  output  1  high while checking (CHECK state)
- done  output  1  one-cycle pulse when result is valid
- valid  output  1  1 = all checked groups passed; held until next accepted start
- err_group  output  5  first failing group index (0-8 row, 9-17 col, 18-26 box), or ERR_NONE; held

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, busy=0, done=0, valid=0, err_group=ERR_NONE, group counter=0, grid register cleared. Reset overrides everything, including mid-CHECK; no done is produced for an aborted run.
- States: IDLE, CHECK, DONE.
- IDLE:
  - start=1 -> capture bin into internal grid register, counter g=0, clear internal fail flag, err_group=ERR_NONE, valid=0, go to CHECK.
  - start=0 -> stay; outputs hold.
- CHECK:
  - busy=1. Each cycle evaluates group g from the captured register only; changes on bin after capture are ignored.
  - Group g passes iff every one of its 9 cells has exactly one bit set AND the OR of its 9 cells == 9'h1FF.
  - Blank cells (0) and multi-bit cells fail.
  - On the first failing group, latch err_group=g. Later failures do not overwrite it.
  - Group membership:
    - g<9: row g, cells g*9+c for c=0..8.
    - 9<=g<18: column k=g-9, cells r*9+k.
    - g>=18: box b=g-18, top-left row 3*(b/3), col 3*(b%3), 3x3 cells.
  - Transition to DONE when g==26, or on a failure when EARLY_EXIT=1. Otherwise g increments.
- DONE: done=1 for exactly one cycle, busy=0, valid=(no failure recorded), then go to IDLE.
- Latency, EARLY_EXIT=0:
  - start sampled at edge E0.
  - busy high cycles 1..27 (group g evaluated in cycle g+1).
  - done high in cycle 28.
  - done is never asserted in a cycle where busy is high.
- Latency, EARLY_EXIT=1: done in cycle f+2, where f = failing group index. A passing grid takes the full 28 cycles.
- start while busy or in DONE: ignored, not queued.
- start in the same cycle as rst: rst wins.
- Back-to-back runs: start asserted in the cycle after done is accepted in IDLE (minimum start-to-start period 29 cycles when EARLY_EXIT=0).
- valid and err_group change only on an accepted start (cleared) and in DONE (final).
- Implementation targets roughly 150-250 lines: group mux, popcount-1 check per cell, 5-bit counter, FSM.

Test Plan:
- Known-solved grid (row r, col c digit = ((r*3 + r/3 + c) % 9)+1), start pulse -> busy cycles 1-27, done at cycle 28, valid=1, err_group=31.
- Same grid with cell (4,4) zeroed -> valid=0, err_group=4 (row 4 first). With EARLY_EXIT=1, done at cycle 6.
- Solved grid with columns 0 and 1 swapped in row 0 only -> rows pass, column 0 fails -> err_group=9, valid=0.
- Grid whose rows and columns are all permutations but boxes are not (row r = shift r of 1..9) -> err_group=18, valid=0.
- Cell (0,0) = 9'b000000011 (multi-bit) in an otherwise solved grid -> err_group=0. Also: bin changed to all-zero during CHECK does not affect the result.
- Assert rst at cycle 10 of a run -> busy=0 and done never pulses. Start while busy is ignored. Fresh start after reset completes normally with valid=1.
